// File: rtl/gaussian_blur_3x3.sv
// Purpose : 3x3 binomial Gaussian (1 2 1 / 2 4 2 / 1 2 1, /16, rounded) over a raw-image SRAM, raster order.
// Latency : 11 cycles per pixel (9 reads, 1 drain, 1 write); gaus_done 1 cycle after the last write.
// Backpres: none; SRAMs are assumed to accept every strobe, start is ignored while busy.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   start, max_x, max_y           frame request and inclusive last column/row (latched at start)
//   raw_rdata                     raw SRAM data, valid the cycle after read_SRAM_raw
//   read_SRAM_raw, x/y_addr_raw   raw SRAM read strobe and address
//   write_SRAM_gaus, x/y_addr_gaus_w, gaus_wdata
//                                 Gaussian SRAM write strobe, address and smoothed pixel
//   gaus_sample_flag, gaus_done   per-pixel pulse and end-of-frame pulse
//   busy                          high whenever the FSM is not idle
module gaussian_blur_3x3 #(
    parameter int X_MAX = 5,
    parameter int Y_MAX = 5,
    localparam int CW = $clog2((X_MAX > Y_MAX) ? X_MAX : Y_MAX),
    localparam int AW = CW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] max_x,
    input  logic [CW-1:0] max_y,
    input  logic [7:0]    raw_rdata,
    output logic          read_SRAM_raw,
    output logic [AW-1:0] x_addr_raw,
    output logic [AW-1:0] y_addr_raw,
    output logic          write_SRAM_gaus,
    output logic [AW-1:0] x_addr_gaus_w,
    output logic [AW-1:0] y_addr_gaus_w,
    output logic [7:0]    gaus_wdata,
    output logic          gaus_sample_flag,
    output logic          gaus_done,
    output logic          busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LAST  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    k_q, k_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic [CW-1:0] mx_q, mx_d, my_q, my_d;
    logic [11:0]   acc_q, acc_d;
    logic [CW-1:0] wx_q, wx_d, wy_q, wy_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [CW-1:0] rx_q, rx_d, ry_q, ry_d;

    // Tap geometry: row/col select 0,1,2 meaning offset -1,0,+1.
    logic [1:0]    row_sel, col_sel;
    logic [CW-1:0] rd_x, rd_y;
    logic [3:0]    prev_tap;
    logic [11:0]   raw_ext, tap_term, acc_sum;

    always_comb begin
        row_sel = 2'd0;
        col_sel = 2'd0;
        case (k_q)
            4'd0:    begin row_sel = 2'd0; col_sel = 2'd0; end
            4'd1:    begin row_sel = 2'd0; col_sel = 2'd1; end
            4'd2:    begin row_sel = 2'd0; col_sel = 2'd2; end
            4'd3:    begin row_sel = 2'd1; col_sel = 2'd0; end
            4'd4:    begin row_sel = 2'd1; col_sel = 2'd1; end
            4'd5:    begin row_sel = 2'd1; col_sel = 2'd2; end
            4'd6:    begin row_sel = 2'd2; col_sel = 2'd0; end
            4'd7:    begin row_sel = 2'd2; col_sel = 2'd1; end
            default: begin row_sel = 2'd2; col_sel = 2'd2; end
        endcase
    end

    // Clamp to [0, max]: border pixels are replicated instead of reading outside the frame.
    always_comb begin
        rd_x = x_q;
        rd_y = y_q;
        if (col_sel == 2'd0)      rd_x = (x_q == '0)   ? '0   : x_q - 1'b1;
        else if (col_sel == 2'd2) rd_x = (x_q >= mx_q) ? mx_q : x_q + 1'b1;
        if (row_sel == 2'd0)      rd_y = (y_q == '0)   ? '0   : y_q - 1'b1;
        else if (row_sel == 2'd2) rd_y = (y_q >= my_q) ? my_q : y_q + 1'b1;
    end

    // Read data lags its address by one cycle, so the tap being accumulated is k-1
    // (or tap 8 in LAST). Weight is 4 at the centre, 2 on odd taps, 1 on corners.
    always_comb begin
        prev_tap = (state_q == LAST) ? 4'd8 : 4'(k_q - 4'd1);
        raw_ext  = {4'b0000, raw_rdata};
        if (prev_tap == 4'd4)  tap_term = raw_ext << 2;
        else if (prev_tap[0])  tap_term = raw_ext << 1;
        else                   tap_term = raw_ext;
        acc_sum = acc_q + tap_term;
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        x_d     = x_q;
        y_d     = y_q;
        mx_d    = mx_q;
        my_d    = my_q;
        acc_d   = acc_q;
        wx_d    = wx_q;
        wy_d    = wy_q;
        wdata_d = wdata_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mx_d    = max_x;
                    my_d    = max_y;
                    x_d     = '0;
                    y_d     = '0;
                    acc_d   = '0;
                    k_d     = 4'd0;
                    state_d = READ;
                end
            end
            READ: begin
                rx_d = rd_x;
                ry_d = rd_y;
                if (k_q != 4'd0) acc_d = acc_sum;
                if (k_q == 4'd8) begin
                    k_d     = 4'd0;
                    state_d = LAST;
                end else begin
                    k_d = k_q + 4'd1;
                end
            end
            LAST: begin
                // Result and write address are registered here so that the write
                // cycle drives them straight from flops and they hold afterwards.
                acc_d   = acc_sum;
                wdata_d = 8'((acc_sum + 12'd8) >> 4);
                wx_d    = x_q;
                wy_d    = y_q;
                state_d = WRITE;
            end
            WRITE: begin
                acc_d = '0;
                if (x_q < mx_q) begin
                    x_d     = x_q + 1'b1;
                    state_d = READ;
                end else if (y_q < my_q) begin
                    x_d     = '0;
                    y_d     = y_q + 1'b1;
                    state_d = READ;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mx_q    <= '0;
            my_q    <= '0;
            acc_q   <= '0;
            wx_q    <= '0;
            wy_q    <= '0;
            wdata_q <= '0;
            rx_q    <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mx_q    <= mx_d;
            my_q    <= my_d;
            acc_q   <= acc_d;
            wx_q    <= wx_d;
            wy_q    <= wy_d;
            wdata_q <= wdata_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
        end
    end

    assign read_SRAM_raw    = (state_q == READ);
    assign x_addr_raw       = {{(AW-CW){1'b0}}, (state_q == READ) ? rd_x : rx_q};
    assign y_addr_raw       = {{(AW-CW){1'b0}}, (state_q == READ) ? rd_y : ry_q};
    assign write_SRAM_gaus  = (state_q == WRITE);
    assign gaus_sample_flag = (state_q == WRITE);
    assign x_addr_gaus_w    = {{(AW-CW){1'b0}}, wx_q};
    assign y_addr_gaus_w    = {{(AW-CW){1'b0}}, wy_q};
    assign gaus_wdata       = wdata_q;
    assign gaus_done        = (state_q == DONE);
    assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_gaussian_blur_3x3.sv
module tb_gaussian_blur_3x3;
    localparam int CW = 3;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] max_x = '0;
    logic [CW-1:0] max_y = '0;
    logic [7:0]    raw_rdata = 8'h00;
    logic          read_SRAM_raw, write_SRAM_gaus, gaus_sample_flag, gaus_done, busy;
    logic [AW-1:0] x_addr_raw, y_addr_raw, x_addr_gaus_w, y_addr_gaus_w;
    logic [7:0]    gaus_wdata;

    gaussian_blur_3x3 #(.X_MAX(5), .Y_MAX(5)) dut (
        .clk(clk), .rst(rst), .start(start), .max_x(max_x), .max_y(max_y),
        .raw_rdata(raw_rdata), .read_SRAM_raw(read_SRAM_raw),
        .x_addr_raw(x_addr_raw), .y_addr_raw(y_addr_raw),
        .write_SRAM_gaus(write_SRAM_gaus), .x_addr_gaus_w(x_addr_gaus_w),
        .y_addr_gaus_w(y_addr_gaus_w), .gaus_wdata(gaus_wdata),
        .gaus_sample_flag(gaus_sample_flag), .gaus_done(gaus_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int last_wr_cyc = 0;
    logic [7:0]    mem    [0:4][0:4];
    logic [7:0]    outimg [0:4][0:4];
    logic [15:0]   exp_q[$];
    logic [CW-1:0] cur_mx = '0;
    logic [CW-1:0] cur_my = '0;

    // Raw SRAM model: one-cycle read latency.
    always @(posedge clk) begin
        if (read_SRAM_raw) begin
            if (x_addr_raw < 5 && y_addr_raw < 5) raw_rdata <= mem[y_addr_raw][x_addr_raw];
            else raw_rdata <= 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int clampi(input int v, input int m);
        if (v < 0) return 0;
        if (v > m) return m;
        return v;
    endfunction

    function automatic logic [7:0] gold(input int x, input int y, input int mx, input int my);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++)
            for (int dx = -1; dx <= 1; dx++)
                s += (2 - (dx < 0 ? -dx : dx)) * (2 - (dy < 0 ? -dy : dy))
                     * int'(mem[clampi(y + dy, my)][clampi(x + dx, mx)]);
        return 8'((s + 8) >> 4);
    endfunction

    // Monitor: read bounds, flag/strobe coincidence, scoreboard pop on each write.
    always @(negedge clk) begin
        if (!rst) begin
            if (read_SRAM_raw)
                check("rd_bounds", {31'd0, (x_addr_raw <= {1'b0, cur_mx}) && (y_addr_raw <= {1'b0, cur_my})}, 1);
            if (write_SRAM_gaus || gaus_sample_flag)
                check("flag_eq_wr", {31'd0, gaus_sample_flag}, {31'd0, write_SRAM_gaus});
            if (write_SRAM_gaus) begin
                check("wr_expected", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check("wr_addr", {24'd0, x_addr_gaus_w, y_addr_gaus_w}, {24'd0, e[15:12], e[11:8]});
                    check("wr_data", {24'd0, gaus_wdata}, {24'd0, e[7:0]});
                end
                if (x_addr_gaus_w < 5 && y_addr_gaus_w < 5) outimg[y_addr_gaus_w][x_addr_gaus_w] = gaus_wdata;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
        end
    end

    task automatic fill(input logic [7:0] v);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) mem[y][x] = v;
    endtask

    // Called at a negedge; pushes expectations, pulses start, returns start cycle.
    task automatic launch(input int mx, input int my, output int c0);
        cur_mx = CW'(mx);
        cur_my = CW'(my);
        max_x  = CW'(mx);
        max_y  = CW'(my);
        for (int y = 0; y <= my; y++)
            for (int x = 0; x <= mx; x++)
                exp_q.push_back({4'(x), 4'(y), gold(x, y, mx, my)});
        start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, input int n, output int seen);
        seen = -1;
        for (int i = 0; i < 11 * n + 30; i++) begin
            if (gaus_done) begin
                seen = cyc;
                break;
            end
            @(negedge clk);
        end
        check("done_cycle", seen, c0 + 11 * n + 1);
        check("queue_drained", exp_q.size(), 0);
        @(negedge clk);
        check("done_pulse_1cyc", {31'd0, gaus_done}, 0);
        check("busy_low", {31'd0, busy}, 0);
    endtask

    initial begin
        int c0, seen, base;
        fill(8'd0);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) outimg[y][x] = 8'hEE;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {3'd0, read_SRAM_raw, x_addr_raw, y_addr_raw, write_SRAM_gaus,
                                x_addr_gaus_w, y_addr_gaus_w, gaus_wdata, gaus_sample_flag,
                                gaus_done, busy}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: uniform 100
        fill(8'd100);
        base = wr_cnt;
        launch(4, 4, c0);
        check("t1_first_read", {31'd0, read_SRAM_raw}, 1);
        wait_done(c0, 25, seen);
        check("t1_done_at_276", seen - c0, 276);
        check("t1_writes", wr_cnt - base, 25);
        check("t1_pix_4_4", {24'd0, outimg[4][4]}, 100);

        // 2: impulse 160 at centre
        fill(8'd0);
        mem[2][2] = 8'd160;
        launch(4, 4, c0);
        wait_done(c0, 25, seen);
        check("t2_centre", {24'd0, outimg[2][2]}, 40);
        check("t2_left",   {24'd0, outimg[2][1]}, 20);
        check("t2_up",     {24'd0, outimg[1][2]}, 20);
        check("t2_diag",   {24'd0, outimg[1][1]}, 10);
        check("t2_far",    {24'd0, outimg[0][0]}, 0);

        // 3: corner replication
        fill(8'd0);
        mem[0][0] = 8'd16;
        launch(4, 4, c0);
        wait_done(c0, 25, seen);
        check("t3_00", {24'd0, outimg[0][0]}, 9);
        check("t3_10", {24'd0, outimg[0][1]}, 3);
        check("t3_01", {24'd0, outimg[1][0]}, 3);
        check("t3_11", {24'd0, outimg[1][1]}, 1);

        // 4: rounding on a small impulse
        fill(8'd0);
        mem[2][2] = 8'd8;
        launch(4, 4, c0);
        wait_done(c0, 25, seen);
        check("t4_centre", {24'd0, outimg[2][2]}, 2);
        check("t4_edge",   {24'd0, outimg[2][3]}, 1);
        check("t4_diag",   {24'd0, outimg[3][3]}, 1);
        check("t4_far",    {24'd0, outimg[0][4]}, 0);

        // 5: start while busy ignored, reset mid-frame, restart from (0,0)
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++) mem[y][x] = 8'($urandom_range(0, 255));
        base = wr_cnt;
        launch(4, 3, c0);
        for (int i = 0; i < 200 && wr_cnt - base < 3; i++) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && wr_cnt - base < 7; i++) @(negedge clk);
        check("t5_reached_px7", wr_cnt - base, 7);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("t5_rst_outputs", {3'd0, read_SRAM_raw, x_addr_raw, y_addr_raw, write_SRAM_gaus,
                                 x_addr_gaus_w, y_addr_gaus_w, gaus_wdata, gaus_sample_flag,
                                 gaus_done, busy}, 0);
        rst = 1'b0;
        @(negedge clk);
        base = wr_cnt;
        launch(4, 3, c0);
        wait_done(c0, 20, seen);
        check("t5_writes", wr_cnt - base, 20);

        // 6: 1x1 frame
        fill(8'd0);
        mem[0][0] = 8'd77;
        launch(0, 0, c0);
        wait_done(c0, 1, seen);
        check("t6_write_cycle", last_wr_cyc - c0, 11);
        check("t6_done_cycle", seen - c0, 12);
        check("t6_value", {24'd0, outimg[0][0]}, 77);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
